// File: rtl/cnn_layer_accel_awe_psum_accum.sv
// cnn_layer_accel_awe_psum_accum: sums num_passes partial-sum beats per result with saturation,
// buffering results in a show-ahead FIFO with sticky overflow/saturation flags.
module cnn_layer_accel_awe_psum_accum #(
  parameter int C_P_OUTPUT_WIDTH = 48,
  parameter int C_PASS_CNT_WIDTH = 8,
  parameter int C_FIFO_DEPTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              new_map,
  input  logic [C_PASS_CNT_WIDTH-1:0]       num_passes,
  input  logic                              datain_valid,
  input  logic [C_P_OUTPUT_WIDTH-1:0]       datain_p,
  input  logic                              datain_c,
  output logic                              dataout_valid,
  input  logic                              dataout_ready,
  output logic [C_P_OUTPUT_WIDTH-1:0]       dataout,
  output logic [$clog2(C_FIFO_DEPTH):0]     fifo_count,
  output logic                              overflow_err,
  output logic                              sat_err
);
  localparam int W  = C_P_OUTPUT_WIDTH;
  localparam int PW = C_PASS_CNT_WIDTH;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t r_state, w_state_nxt;
  logic [PW-1:0] r_passes, r_pass_cnt, w_passes_eff, w_cnt_eff;
  logic [W-1:0]  r_acc, w_sum_sat, w_acc_nxt;
  logic [W:0]    w_sum_ext;
  logic          w_sum_ovf, w_beat, w_last, w_sat_hit;
  logic [W-1:0]  r_mem [C_FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf, r_sat, w_full, w_pop, w_push, w_drop;
  logic          w_unused;
  assign w_unused = datain_c;
  always_comb w_state_nxt = new_map ? ACCUM : r_state;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_state_nxt;
  // A new_map beat counts as pass 0 of the freshly armed map, so use the incoming config
  always_comb begin
    w_beat       = datain_valid && (new_map || r_state == ACCUM);
    w_passes_eff = new_map ? ((num_passes == '0) ? PW'(1) : num_passes) : r_passes;
    w_cnt_eff    = new_map ? '0 : r_pass_cnt;
    w_last       = w_beat && (w_cnt_eff == w_passes_eff - PW'(1));
  end
  // Sign-extend by one bit; a mismatch between the top two bits means signed overflow
  always_comb begin
    w_sum_ext = {r_acc[W-1], r_acc} + {datain_p[W-1], datain_p};
    w_sum_ovf = w_sum_ext[W] ^ w_sum_ext[W-1];
    w_sum_sat = !w_sum_ovf ? w_sum_ext[W-1:0] : (w_sum_ext[W] ? MIN_V : MAX_V);
    w_acc_nxt = (w_cnt_eff == '0) ? datain_p : w_sum_sat;
    w_sat_hit = w_beat && (w_cnt_eff != '0) && w_sum_ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_passes   <= PW'(1);
      r_pass_cnt <= '0;
      r_acc      <= '0;
    end else begin
      r_passes   <= w_passes_eff;
      r_pass_cnt <= w_beat ? (w_last ? '0 : w_cnt_eff + PW'(1)) : w_cnt_eff;
      r_acc      <= w_beat ? w_acc_nxt : (new_map ? '0 : r_acc);
    end
  end
  // A full FIFO still accepts a result when the head is popped in the same cycle
  always_comb begin
    w_full = r_count == (AW+1)'(C_FIFO_DEPTH);
    w_pop  = (r_count != '0) && dataout_ready;
    w_push = w_last && (!w_full || w_pop);
    w_drop = w_last && w_full && !w_pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf   <= w_drop || (r_ovf && !new_map);
      r_sat   <= w_sat_hit || (r_sat && !new_map);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= w_acc_nxt;
  assign dataout_valid = r_count != '0;
  assign dataout       = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign fifo_count    = r_count;
  assign overflow_err  = r_ovf;
  assign sat_err       = r_sat;
endmodule

// File: tb/tb_cnn_layer_accel_awe_psum_accum.sv
// tb_cnn_layer_accel_awe_psum_accum: directed and randomized checks against a queue-based
// behavioural model of the partial-sum accumulator.
module tb_cnn_layer_accel_awe_psum_accum;
  localparam int W  = 48;
  localparam int PW = 8;
  localparam int D  = 16;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));
  logic clk = 1'b0;
  logic rst, new_map, datain_valid, datain_c, dataout_ready;
  logic [PW-1:0] num_passes;
  logic [W-1:0] datain_p, dataout;
  logic dataout_valid, overflow_err, sat_err;
  logic [$clog2(D):0] fifo_count;
  int n_tests = 0, n_fail = 0;
  bit m_armed, m_ovf, m_sat;
  longint m_passes, m_cnt, m_acc;
  longint m_q[$];
  cnn_layer_accel_awe_psum_accum #(.C_P_OUTPUT_WIDTH(W), .C_PASS_CNT_WIDTH(PW), .C_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .new_map(new_map), .num_passes(num_passes),
    .datain_valid(datain_valid), .datain_p(datain_p), .datain_c(datain_c),
    .dataout_valid(dataout_valid), .dataout_ready(dataout_ready), .dataout(dataout),
    .fifo_count(fifo_count), .overflow_err(overflow_err), .sat_err(sat_err));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(bit r, bit nm, longint np, bit v, longint p, bit rdy);
    longint s;
    if (r) begin
      m_armed = 0; m_passes = 1; m_cnt = 0; m_acc = 0; m_ovf = 0; m_sat = 0;
      m_q.delete();
      return;
    end
    if (nm) begin
      m_armed = 1; m_passes = (np == 0) ? 1 : np; m_cnt = 0; m_acc = 0; m_ovf = 0; m_sat = 0;
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (v && m_armed) begin
      if (m_cnt == 0) m_acc = p;
      else begin
        s = m_acc + p;
        if (s > MAXV) begin s = MAXV; m_sat = 1; end
        else if (s < MINV) begin s = MINV; m_sat = 1; end
        m_acc = s;
      end
      if (m_cnt == m_passes - 1) begin
        if (m_q.size() < D) m_q.push_back(m_acc);
        else m_ovf = 1;
        m_cnt = 0;
      end else m_cnt++;
    end
  endtask
  task automatic step(bit r, bit nm, logic [PW-1:0] np, bit v, longint p, bit rdy);
    longint h;
    @(negedge clk);
    rst = r; new_map = nm; num_passes = np; datain_valid = v;
    datain_p = p[W-1:0]; datain_c = 1'($urandom); dataout_ready = rdy;
    model(r, nm, longint'(np), v, p, rdy);
    @(posedge clk);
    #1;
    h = (m_q.size() > 0) ? m_q[0] : 0;
    check("valid", 64'(dataout_valid), 64'(m_q.size() > 0));
    check("dataout", 64'(dataout), 64'(h[W-1:0]));
    check("count", 64'(fifo_count), 64'(m_q.size()));
    check("ovf", 64'(overflow_err), 64'(m_ovf));
    check("sat", 64'(sat_err), 64'(m_sat));
  endtask
  function automatic longint rand_p();
    logic [W-1:0] r;
    r = {$urandom, $urandom};
    case ($urandom % 4)
      0: return MAXV;
      1: return MINV;
      2: return longint'($urandom_range(2000)) - 1000;
      default: return longint'($signed(r));
    endcase
  endfunction
  initial begin
    rst = 1; new_map = 0; num_passes = 0; datain_valid = 0; datain_p = 0; datain_c = 0; dataout_ready = 0;
    step(1, 1, 3, 1, 55, 1);
    step(1, 1, 2, 1, 66, 1);
    // three-pass sum 5-2+10
    step(0, 1, 3, 1, 5, 1);
    step(0, 0, 0, 1, -2, 1);
    step(0, 0, 0, 1, 10, 1);
    check("r033_val", 64'(dataout), 64'd13);
    step(0, 0, 0, 0, 0, 1);
    check("r033_once", 64'(dataout_valid), 64'd0);
    // num_passes 0 behaves as 1
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0);
    step(0, 0, 0, 1, 9, 0);
    check("r034_cnt", 64'(fifo_count), 64'd2);
    check("r034_head", 64'(dataout), 64'd7);
    step(0, 0, 0, 0, 0, 1);
    check("r034_next", 64'(dataout), 64'd9);
    step(0, 0, 0, 0, 0, 1);
    // positive saturation twice
    step(0, 1, 2, 1, 64'sd1 <<< 46, 1);
    step(0, 0, 0, 1, 64'sd1 <<< 46, 1);
    check("r035_a", 64'(dataout), 64'(MAXV));
    step(0, 0, 0, 1, MAXV, 1);
    step(0, 0, 0, 1, 1, 1);
    check("r035_b", 64'(dataout), 64'(MAXV));
    check("r035_sat", 64'(sat_err), 64'd1);
    step(0, 0, 0, 0, 0, 1);
    // overflow on 17th result, then in-order drain
    step(0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 17; i++) step(0, 0, 0, 1, i, 0);
    check("r036_cnt", 64'(fifo_count), 64'd16);
    check("r036_ovf", 64'(overflow_err), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      check("r036_drain", 64'(dataout), 64'(i));
      step(0, 0, 0, 0, 0, 1);
    end
    // full FIFO, push coincident with pop
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 100 + i, 0);
    step(0, 0, 0, 1, 200, 1);
    check("r037_cnt", 64'(fifo_count), 64'd16);
    check("r037_ovf", 64'(overflow_err), 64'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1);
    // reset and re-arm discard partial sums
    step(0, 1, 4, 1, 50, 1);
    step(0, 0, 0, 1, 60, 1);
    step(1, 1, 2, 1, 70, 1);
    step(0, 1, 2, 1, 3, 1);
    step(0, 0, 0, 1, 4, 1);
    check("r038_rst", 64'(dataout), 64'd7);
    step(0, 1, 3, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 1, 2, 1, 5, 1);
    step(0, 0, 0, 1, 6, 1);
    check("r038_remap", 64'(dataout), 64'd11);
    // beats while idle are ignored
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 9, 1);
    check("idle_drop", 64'(fifo_count), 64'd0);
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 300) % 2 == 0) ? 20 : 80;
      step($urandom_range(399) == 0, $urandom_range(39) == 0, PW'($urandom_range(5)),
           $urandom_range(99) < 70, rand_p(), $urandom_range(99) < rdy_pct);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
